// File: rtl/regfile_sb.sv
// Parametrised RISC-16 register file: two registered read ports, one muxed write-back port,
// and a per-register busy scoreboard. Define REGFILE_SB_BYPASS_EN to forward write-back data to reads.
module regfile_sb #(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 8,
    parameter  int ZERO_R0  = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              stall,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [1:0]        wb_src,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] mem_out,
    input  logic [DATA_W-1:0] pc
);

    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_MEM  = 2'd1;
    localparam logic [1:0] SRC_LINK = 2'd2;
    localparam logic [1:0] SRC_NONE = 2'd3;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic [DATA_W-1:0] wdata_p0;
    logic              wb_store_p0;
    logic              wr_fire_p0;
    logic [DATA_W-1:0] rd_val1_p0;
    logic [DATA_W-1:0] rd_val2_p0;
    logic              hit1_p0;
    logic              hit2_p0;

    // Link address wraps at 2^DATA_W.
    function automatic logic [DATA_W-1:0] inc_wrap(input logic [DATA_W-1:0] v);
        return v + DATA_W'(1);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    always_comb begin
        wdata_p0 = alu_out;
        case (wb_src)
            SRC_ALU:  wdata_p0 = alu_out;
            SRC_MEM:  wdata_p0 = mem_out;
            SRC_LINK: wdata_p0 = inc_wrap(pc);
            default:  wdata_p0 = alu_out;
        endcase
    end

    assign wb_store_p0 = wb_en && (wb_src != SRC_NONE);
    assign wr_fire_p0  = wb_store_p0 && !is_zero_reg(wb_addr);

    // Read-side value selection; forwarding only exists in the bypass build.
    function automatic logic [DATA_W-1:0] read_value(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = regs[a];
        if (is_zero_reg(a)) begin
            v = '0;
        end
`ifdef REGFILE_SB_BYPASS_EN
        else if (wb_store_p0 && (wb_addr == a)) begin
            v = wdata_p0;
        end
`endif
        return v;
    endfunction

    assign rd_val1_p0 = read_value(rd_addr1);
    assign rd_val2_p0 = read_value(rd_addr2);

`ifdef REGFILE_SB_BYPASS_EN
    assign hit1_p0 = wb_en && (wb_addr == rd_addr1);
    assign hit2_p0 = wb_en && (wb_addr == rd_addr2);
`else
    assign hit1_p0 = 1'b0;
    assign hit2_p0 = 1'b0;
`endif

    assign stall = rd_en && ((busy[rd_addr1] && !hit1_p0) || (busy[rd_addr2] && !hit2_p0));

    // Stage p0 -> p1: register array write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_fire_p0) begin
            regs[wb_addr] <= wdata_p0;
        end
    end

    // A fresh issue outranks a same-cycle write-back so the new writer stays tracked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int n = 0; n < NUM_REGS; n++) begin
                if (issue_en && (issue_addr == ADDR_W'(n)) && !is_zero_reg(issue_addr)) begin
                    busy[n] <= 1'b1;
                end else if (wb_en && (wb_addr == ADDR_W'(n))) begin
                    busy[n] <= 1'b0;
                end
            end
        end
    end

    // Stage p0 -> p1: registered read ports
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else if (rd_en) begin
            rd_data1 <= rd_val1_p0;
            rd_data2 <= rd_val2_p0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: expected read data is queued when a read is driven
// and compared one cycle later when the registered ports update.
module tb_regfile_sb;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr1, rd_addr2;
    logic [DATA_W-1:0] rd_data1, rd_data2;
    logic              stall;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [1:0]        wb_src;
    logic [DATA_W-1:0] alu_out, mem_out, pc;

    typedef struct {
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        string             tag;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int n_chk  = 0;
    int n_fail = 0;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_sb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ZERO_R0(1)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .stall(stall),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_src(wb_src),
        .alu_out(alu_out), .mem_out(mem_out), .pc(pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_read(input string tag, input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2);
        rd_exp_t e;
        e.d1 = e1;
        e.d2 = e2;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        rd_exp_t e;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, "_d1"}, 32'(rd_data1), 32'(e.d1));
            chk({e.tag, "_d2"}, 32'(rd_data2), 32'(e.d2));
        end
    endtask

    task automatic do_wb(input logic [ADDR_W-1:0] a, input logic [1:0] src, input logic [DATA_W-1:0] v);
        wb_en = 1'b1; wb_addr = a; wb_src = src;
        alu_out = v; mem_out = v; pc = v;
        tick();
        wb_en = 1'b0; wb_src = 2'd3;
    endtask

    task automatic do_issue(input logic [ADDR_W-1:0] a);
        issue_en = 1'b1; issue_addr = a;
        tick();
        issue_en = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                           input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2, input logic exp_stall);
        rd_en = 1'b1; rd_addr1 = a1; rd_addr2 = a2;
        #1;
        chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
        push_read(tag, e1, e2);
        tick();
        rd_en = 1'b0;
        pop_check();
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
        issue_en = 1'b0; issue_addr = '0; wb_en = 1'b0; wb_addr = '0; wb_src = 2'd3;
        alu_out = '0; mem_out = '0; pc = '0;
        repeat (2) tick();
        chk("rst_d1", 32'(rd_data1), 32'd0);
        chk("rst_d2", 32'(rd_data2), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        tick();

        // Mid-run reset with r3 written and busy
        do_wb(3'd3, 2'd0, 16'h1234);
        do_read("r3_pre", 3'd3, 3'd3, 16'h1234, 16'h1234, 1'b0);
        do_issue(3'd3);
        rd_en = 1'b1; rd_addr1 = 3'd3; rd_addr2 = 3'd3;
        #1;
        chk("r3_busy_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_d1", 32'(rd_data1), 32'd0);
        chk("midrst_d2", 32'(rd_data2), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        tick();
        rst = 1'b0; rd_en = 1'b0;
        do_read("r3_post", 3'd3, 3'd3, 16'h0000, 16'h0000, 1'b0);

        // r0 hardwired
        do_wb(3'd0, 2'd0, 16'hBEEF);
        do_issue(3'd0);
        do_read("r0", 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0);

        // Source mux
        do_wb(3'd5, 2'd2, 16'hFFFF);
        do_read("pc_wrap", 3'd5, 3'd0, 16'h0000, 16'h0000, 1'b0);
        do_wb(3'd6, 2'd1, 16'hA5A5);
        do_read("mem_src", 3'd6, 3'd5, 16'hA5A5, 16'h0000, 1'b0);
        do_issue(3'd6);
        do_read("r6_busy", 3'd0, 3'd6, 16'h0000, 16'hA5A5, 1'b1);
        do_wb(3'd6, 2'd3, 16'h1111);
        do_read("nowrite", 3'd6, 3'd6, 16'hA5A5, 16'hA5A5, 1'b0);

        // Stall on r2 until write-back
        do_issue(3'd2);
        do_read("r2_busy", 3'd1, 3'd2, 16'h0000, 16'h0000, 1'b1);
        rd_en = 1'b1; rd_addr1 = 3'd1; rd_addr2 = 3'd2;
        wb_en = 1'b1; wb_addr = 3'd2; wb_src = 2'd0; alu_out = 16'h2222;
        #1;
        chk("r2_wb_stall", 32'(stall), BYP ? 32'd0 : 32'd1);
        push_read("r2_wb", 16'h0000, BYP ? 16'h2222 : 16'h0000);
        tick();
        rd_en = 1'b0; wb_en = 1'b0; wb_src = 2'd3;
        pop_check();
        do_read("r2_after", 3'd1, 3'd2, 16'h0000, 16'h2222, 1'b0);

        // Simultaneous issue and write-back on r4
        do_issue(3'd4);
        issue_en = 1'b1; issue_addr = 3'd4;
        wb_en = 1'b1; wb_addr = 3'd4; wb_src = 2'd0; alu_out = 16'h4444;
        tick();
        issue_en = 1'b0; wb_en = 1'b0; wb_src = 2'd3;
        do_read("r4_still_busy", 3'd4, 3'd4, 16'h4444, 16'h4444, 1'b1);
        do_wb(3'd4, 2'd0, 16'h4545);
        do_read("r4_clear", 3'd4, 3'd4, 16'h4545, 16'h4545, 1'b0);

        // Read ports hold while rd_en is low
        do_wb(3'd1, 2'd0, 16'h0011);
        do_read("r1_first", 3'd1, 3'd0, 16'h0011, 16'h0000, 1'b0);
        rd_addr1 = 3'd1;
        tick();
        chk("hold_c1", 32'(rd_data1), 32'h0011);
        do_wb(3'd1, 2'd0, 16'h0022);
        chk("hold_c2", 32'(rd_data1), 32'h0011);
        tick();
        chk("hold_c3", 32'(rd_data1), 32'h0011);
        do_read("r1_second", 3'd1, 3'd0, 16'h0022, 16'h0000, 1'b0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised register file for the RISC-16 datapath, the successor to the fixed 8x16 register file.
- Provides two registered read ports and one write port with a selectable write-back source (ALU, memory, PC+1).
- Hardwires register 0 to zero.
- Adds a per-register busy scoreboard that raises a stall when a read targets a register with an outstanding write. Sits between decode (reads and issue) and write-back.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 8, number of registers; power of two, at least 2.
- ADDR_W, $clog2(NUM_REGS), register address width; localparam derived from NUM_REGS, not overridable.
- ZERO_R0, 1, 1 = register 0 reads as 0 and ignores writes/issues; 0 = register 0 is ordinary.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  1  capture read data this cycle.
- rd_addr1  in  ADDR_W  read port 1 address (rA).
- rd_addr2  in  ADDR_W  read port 2 address (rB/rC).
- rd_data1  out  DATA_W  registered read data, port 1.
- rd_data2  out  DATA_W  registered read data, port 2.
- stall  out  1  combinational; a read address is busy.
- issue_en  in  1  mark issue_addr busy (instruction with destination leaves decode).
- issue_addr  in  ADDR_W  destination of issued instruction.
- wb_en  in  1  write-back strobe.
- wb_addr  in  ADDR_W  write-back destination.
- wb_src  in  2  0 = alu_out, 1 = mem_out, 2 = pc+1, 3 = no write.
- alu_out  in  DATA_W  ALU result.
- mem_out  in  DATA_W  memory load data.
- pc  in  DATA_W  current PC of the write-back instruction.

Behaviour:
- Reset (rst high, asynchronous): all registers = 0, all busy bits = 0, rd_data1/rd_data2 = 0. stall follows busy, so it is 0.
- Write data: wdata = mux(wb_src).
  - pc+1 is computed modulo 2^DATA_W, so 16'hFFFF+1 = 0.
  - wb_src=3 suppresses the register write but still clears the busy bit.
- Write:
  - On a rising edge with wb_en=1 and wb_src!=3, reg[wb_addr] <= wdata.
  - Writes to addr 0 are ignored when ZERO_R0=1.
- Read:
  - On a rising edge with rd_en=1, rd_data1 <= reg[rd_addr1] and rd_data2 <= reg[rd_addr2]. Latency is 1 cycle.
  - When rd_en=0, rd_data holds its value.
  - Addr 0 reads as 0 when ZERO_R0=1.
- Scoreboard:
  - busy[n] is set on a rising edge with issue_en=1 and issue_addr=n.
  - busy[n] is cleared on a rising edge with wb_en=1 and wb_addr=n.
  - Issue and write-back to the same address in one cycle: busy stays 1. The new issue wins; the write still lands.
  - Issue to addr 0 is ignored when ZERO_R0=1.
  - Re-issue to an already-busy register leaves it busy. There is a single bit, no count; decode must not issue two writers to one register.
- Stall:
  - stall = rd_en & ((busy[rd_addr1] & ~hit1) | (busy[rd_addr2] & ~hit2)).
  - hitN = wb_en & (wb_addr==rd_addrN), and only when BYPASS_EN is defined; otherwise hitN = 0.
  - Decode is responsible for not issuing while stall=1. The block does not gate issue_en.
- Reset mid-operation: all pending busy bits are dropped immediately; no write completes on that edge.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined:
  - On a read when wb_en=1, wb_src!=3 and wb_addr matches rd_addrN (non-zero, or ZERO_R0=0), rd_dataN captures wdata instead of the stale register.
  - A matching write-back with wb_src=3 still suppresses stall for that port but returns the stored register value.
  - stall is suppressed for that port as defined above.
- Not defined:
  - A same-cycle read returns the pre-write value.
  - stall remains asserted until the cycle after busy clears.

Test Plan:
- Reset: assert rst mid-run with busy[3]=1 and reg[3]=16'h1234 -> rd_data1/rd_data2=0, stall=0, and a later read of r3 returns 0.
- R0 protection: wb_en, wb_addr=0, wb_src=0, alu_out=16'hBEEF, then read r0 -> rd_data1=0.
  - issue_addr=0 never produces stall.
- Source mux:
  - wb_src=2 with pc=16'hFFFF to r5 -> r5 reads 16'h0000.
  - wb_src=1 with mem_out=16'hA5A5 to r6 -> r6 reads 16'hA5A5.
  - wb_src=3 -> r6 unchanged and busy[6] cleared.
- Scoreboard stall: issue r2, next cycle rd_en with rd_addr2=2 -> stall=1.
  - wb_en to r2 -> without the macro, stall=1 that cycle and 0 the next.
  - With REGFILE_SB_BYPASS_EN, stall=0 in the write-back cycle and rd_data2 = written value.
- Simultaneous issue and write-back to r4 -> busy[4] remains 1 and reg[4] is updated; a read of r4 after a second write-back clears stall.
- Hold: rd_en=0 for 3 cycles while r1 changes 16'h0011 -> 16'h0022 -> rd_data1 stays 16'h0011 until rd_en=1.
